// File: rtl/avalon_udp_pkg.sv
// Shared types and constants for the single-outstanding Avalon-MM master:
// FSM state encoding, bus width and default timing parameters.
package avalon_udp_pkg;

  localparam int BUS_W            = 16;
  localparam int DEF_READ_LATENCY = 2;
  localparam int DEF_TIMEOUT      = 255;

  typedef logic [BUS_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/avalon_master_udp_if.sv
// Command/response channel plus Avalon-MM bus signals of the master.
// The master modport is the DUT side; the slave modport is the environment side.
interface avalon_master_udp_if;
  import avalon_udp_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  logic  cmd_wr;
  word_t cmd_addr;
  word_t cmd_wdata;

  logic  rsp_valid;
  word_t rsp_rdata;
  logic  rsp_err;

  logic  avm_chipselect_n;
  logic  avm_write_n;
  logic  avm_read_n;
  word_t avm_address;
  word_t avm_writedata;
  word_t avm_readdata;
  logic  avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           avm_chipselect_n, avm_write_n, avm_read_n, avm_address, avm_writedata
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           avm_chipselect_n, avm_write_n, avm_read_n, avm_address, avm_writedata
  );

endinterface

// File: rtl/avm_wait_timer.sv
// Saturating cycle counter with synchronous clear; terminal_o flags that the
// current count equals last_i. Shared by the waitrequest timeout and read latency.
module avm_wait_timer
  import avalon_udp_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear_i,
  input  logic  enable_i,
  input  word_t last_i,
  output logic  terminal_o
);

  word_t count_q, count_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == last_i);

endmodule

// File: rtl/avalon_master_udp.sv
// Single-outstanding Avalon-MM master: one command in, one registered bus
// access out, one completion pulse back (with timeout abort on stuck waitrequest).
module avalon_master_udp
  import avalon_udp_pkg::*;
#(
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  avalon_master_udp_if.master bus
);

  localparam word_t RdLast    = word_t'(READ_LATENCY - 1);
  localparam word_t WaitLast  = word_t'(TIMEOUT - 1);
  localparam bit    TimeoutEn = (TIMEOUT != 0);

  state_e state_q, state_d;
  logic   wr_q, wr_d;
  word_t  addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic   cs_n_q, cs_n_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic   rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

  logic   accept, timed_out, timer_term, timer_clear, timer_en;
  word_t  timer_last;

  assign accept    = (state_q == ST_IDLE) && bus.cmd_valid;
  // A falling waitrequest always wins over the timeout in the same cycle.
  assign timed_out = TimeoutEn && (state_q == ST_ACCESS) && bus.avm_waitrequest && timer_term;

  // One timer serves both phases: waitrequest stall count in ACCESS, latency in RDWAIT.
  assign timer_clear = (state_d != state_q);
  assign timer_en    = ((state_q == ST_ACCESS) && bus.avm_waitrequest) || (state_q == ST_RDWAIT);
  assign timer_last  = (state_q == ST_RDWAIT) ? RdLast : WaitLast;

  avm_wait_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (timer_clear),
    .enable_i   (timer_en),
    .last_i     (timer_last),
    .terminal_o (timer_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (!bus.avm_waitrequest) state_d = wr_q ? ST_RESP : ST_RDWAIT;
        else if (timed_out)       state_d = ST_RESP;
      end
      ST_RDWAIT: if (timer_term) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bus and response outputs are computed from the next state and registered.
  always_comb begin
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      wr_d    = bus.cmd_wr;
      addr_d  = bus.cmd_addr;
      wdata_d = bus.cmd_wdata;
    end
    cs_n_d      = (state_d != ST_ACCESS);
    wr_n_d      = !((state_d == ST_ACCESS) && wr_d);
    rd_n_d      = !((state_d == ST_ACCESS) && !wr_d);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = timed_out;
    rdata_d     = ((state_q == ST_RDWAIT) && (state_d == ST_RESP)) ? bus.avm_readdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready        = (state_q == ST_IDLE);
  assign bus.avm_chipselect_n = cs_n_q;
  assign bus.avm_write_n      = wr_n_q;
  assign bus.avm_read_n       = rd_n_q;
  assign bus.avm_address      = addr_q;
  assign bus.avm_writedata    = wdata_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.rsp_rdata        = rdata_q;

endmodule

// File: tb/tb_avalon_master_udp.sv
// Directed bench for avalon_master_udp (READ_LATENCY=2, TIMEOUT=4): writes,
// reads, stalls, timeout, reset mid-read and back-to-back commands.
module tb_avalon_master_udp;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  avalon_master_udp_if bus ();

  avalon_master_udp #(
    .READ_LATENCY (2),
    .TIMEOUT      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int acc, rsp_n, strobe_n, busy_n, overlap_n;

    rst                 = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cmd_wr          = 1'b0;
    bus.cmd_addr        = '0;
    bus.cmd_wdata       = '0;
    bus.avm_readdata    = '0;
    bus.avm_waitrequest = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_cs_n",   32'(bus.avm_chipselect_n), 32'd1);
    check("rst_wr_n",   32'(bus.avm_write_n),      32'd1);
    check("rst_rd_n",   32'(bus.avm_read_n),       32'd1);
    check("rst_addr",   32'(bus.avm_address),      32'h0);
    check("rst_wdata",  32'(bus.avm_writedata),    32'h0);
    check("rst_rvalid", 32'(bus.rsp_valid),        32'd0);
    check("rst_err",    32'(bus.rsp_err),          32'd0);
    check("rst_rdata",  32'(bus.rsp_rdata),        32'h0);
    rst = 1'b0;
    tick();
    check("rst_ready",  32'(bus.cmd_ready),        32'd1);

    // Zero-wait write: strobe at T+1 only, response at T+2
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 16'h0012; bus.cmd_wdata = 16'hBEEF;
    tick();
    bus.cmd_valid = 1'b0;
    check("wr_strobe",  32'(bus.avm_write_n),      32'd0);
    check("wr_cs",      32'(bus.avm_chipselect_n), 32'd0);
    check("wr_rd_n",    32'(bus.avm_read_n),       32'd1);
    check("wr_addr",    32'(bus.avm_address),      32'h0012);
    check("wr_data",    32'(bus.avm_writedata),    32'hBEEF);
    check("wr_busy",    32'(bus.cmd_ready),        32'd0);
    check("wr_norsp",   32'(bus.rsp_valid),        32'd0);
    tick();
    check("wr_strobe_off", 32'(bus.avm_write_n),   32'd1);
    check("wr_cs_off",  32'(bus.avm_chipselect_n), 32'd1);
    check("wr_rsp",     32'(bus.rsp_valid),        32'd1);
    check("wr_err",     32'(bus.rsp_err),          32'd0);
    check("wr_rdata",   32'(bus.rsp_rdata),        32'h0);
    tick();
    check("wr_rsp_end", 32'(bus.rsp_valid),        32'd0);
    check("wr_idle",    32'(bus.cmd_ready),        32'd1);

    // Zero-wait read: readdata sampled at end of A+2, response at A+3
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 16'h0034;
    tick();
    bus.cmd_valid = 1'b0;
    check("rd_strobe",  32'(bus.avm_read_n),       32'd0);
    check("rd_wr_n",    32'(bus.avm_write_n),      32'd1);
    check("rd_addr",    32'(bus.avm_address),      32'h0034);
    tick();
    bus.avm_readdata = 16'h1111;
    check("rd_strobe_off", 32'(bus.avm_read_n),    32'd1);
    check("rd_cs_off",  32'(bus.avm_chipselect_n), 32'd1);
    check("rd_wait1",   32'(bus.rsp_valid),        32'd0);
    tick();
    bus.avm_readdata = 16'h5A5A;
    check("rd_wait2",   32'(bus.rsp_valid),        32'd0);
    tick();
    bus.avm_readdata = 16'h0000;
    check("rd_rsp",     32'(bus.rsp_valid),        32'd1);
    check("rd_rdata",   32'(bus.rsp_rdata),        32'h5A5A);
    check("rd_err",     32'(bus.rsp_err),          32'd0);
    tick();
    check("rd_rsp_end", 32'(bus.rsp_valid),        32'd0);
    check("rd_rdata_clr", 32'(bus.rsp_rdata),      32'h0);

    // Write stalled 3 cycles (counter reaches TIMEOUT-1 as waitrequest drops)
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 16'h0100; bus.cmd_wdata = 16'h1234;
    bus.avm_waitrequest = 1'b1;
    tick();
    bus.cmd_valid = 1'b0; bus.cmd_addr = 16'hFFFF; bus.cmd_wdata = 16'hFFFF;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) bus.avm_waitrequest = 1'b0;
      check($sformatf("stall_strobe%0d", i), 32'(bus.avm_write_n),   32'd0);
      check($sformatf("stall_addr%0d", i),   32'(bus.avm_address),   32'h0100);
      check($sformatf("stall_data%0d", i),   32'(bus.avm_writedata), 32'h1234);
      check($sformatf("stall_norsp%0d", i),  32'(bus.rsp_valid),     32'd0);
      tick();
    end
    check("stall_strobe_off", 32'(bus.avm_write_n), 32'd1);
    check("stall_rsp",  32'(bus.rsp_valid),        32'd1);
    check("stall_err",  32'(bus.rsp_err),          32'd0);
    tick();
    check("stall_single", 32'(bus.rsp_valid),      32'd0);

    // Read with waitrequest stuck high: abort after 4 strobe cycles
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 16'h0200;
    bus.avm_waitrequest = 1'b1; bus.avm_readdata = 16'hFFFF;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_strobe%0d", i), 32'(bus.avm_read_n), 32'd0);
      check($sformatf("to_norsp%0d", i),  32'(bus.rsp_valid),  32'd0);
      tick();
    end
    check("to_strobe_off", 32'(bus.avm_read_n),    32'd1);
    check("to_cs_off",  32'(bus.avm_chipselect_n), 32'd1);
    check("to_rsp",     32'(bus.rsp_valid),        32'd1);
    check("to_err",     32'(bus.rsp_err),          32'd1);
    check("to_rdata",   32'(bus.rsp_rdata),        32'h0);
    bus.avm_waitrequest = 1'b0;
    tick();
    check("to_rsp_end", 32'(bus.rsp_valid),        32'd0);
    check("to_err_clr", 32'(bus.rsp_err),          32'd0);
    check("to_idle",    32'(bus.cmd_ready),        32'd1);

    // Reset during RDWAIT: no response ever, ready right after reset
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 16'h0300; bus.avm_readdata = 16'hABCD;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_rd_n", 32'(bus.avm_read_n),       32'd1);
    check("rstmid_cs_n", 32'(bus.avm_chipselect_n), 32'd1);
    check("rstmid_norsp", 32'(bus.rsp_valid),       32'd0);
    rst = 1'b0;
    check("rstmid_ready", 32'(bus.cmd_ready),       32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rstmid_quiet%0d", i), 32'(bus.rsp_valid), 32'd0);
    end

    // cmd_valid held high for three reads
    acc = 0; rsp_n = 0; strobe_n = 0; busy_n = 0; overlap_n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 16'h0400;
    bus.avm_readdata = 16'h7E57; bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (acc == 3) bus.cmd_valid = 1'b0;
      if (bus.cmd_valid && bus.cmd_ready) acc++;
      if (bus.rsp_valid) begin
        rsp_n++;
        check($sformatf("b2b_rdata%0d", rsp_n), 32'(bus.rsp_rdata), 32'h7E57);
      end
      if (!bus.avm_read_n) strobe_n++;
      if (!bus.avm_chipselect_n && bus.cmd_ready) busy_n++;
      if (!bus.avm_read_n && !bus.avm_write_n) overlap_n++;
      tick();
    end
    check("b2b_accepts", 32'(acc),       32'd3);
    check("b2b_rsps",    32'(rsp_n),     32'd3);
    check("b2b_strobes", 32'(strobe_n),  32'd3);
    check("b2b_busy",    32'(busy_n),    32'd0);
    check("b2b_overlap", 32'(overlap_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_master_udp.md
AVALON_MASTER_UDP -- requirements
Module: avalon_master_udp

Interface
REQ-001 Parameter READ_LATENCY, default 2: cycles from read acceptance (waitrequest low) to valid avm_readdata; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 255: consecutive waitrequest-high strobe cycles before abort; 0 disables the timeout; legal range 0..65535.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_wr  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  16  word address.
REQ-009 cmd_wdata  in  16  write data.
REQ-010 rsp_valid  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata  out  16  read data, valid with rsp_valid; 0 for writes and errors.
REQ-012 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-013 avm_chipselect_n  out  1  active-low chip select.
REQ-014 avm_write_n / avm_read_n  out  1 each  active-low strobes.
REQ-015 avm_address  out  16  registered address.
REQ-016 avm_writedata  out  16  registered write data.
REQ-017 avm_readdata  in  16  slave read data.
REQ-018 avm_waitrequest  in  1  slave stall, active-high.

Function
REQ-019 States: IDLE, ACCESS, RDWAIT, RESP; all avm_* outputs and rsp_* outputs registered.
REQ-020 cmd_ready shall be 1 only in IDLE; in IDLE all strobes and chipselect_n are 1.
REQ-021 Handshake in cycle T shall capture cmd_addr/cmd_wdata/cmd_wr and enter ACCESS with chipselect_n=0 and write_n=0 (write) or read_n=0 (read) from cycle T+1.
REQ-022 In ACCESS, avm_address/avm_writedata shall be held stable; the access completes at the edge ending cycle A in which avm_waitrequest=0.
REQ-023 Write completion: RESP in cycle A+1 (strobes high, rsp_valid=1, rsp_err=0, rsp_rdata=0), IDLE in A+2.
REQ-024 Read completion: strobes high from A+1; RDWAIT for cycles A+1..A+READ_LATENCY; avm_readdata sampled at end of A+READ_LATENCY; RESP in A+READ_LATENCY+1 with rsp_rdata=sample, rsp_err=0.
REQ-025 Wait counter (16-bit) shall count ACCESS cycles with waitrequest=1, clear on entering ACCESS, and not wrap.
REQ-026 With TIMEOUT>0, if waitrequest is high for TIMEOUT consecutive ACCESS cycles, the next cycle shall be RESP with strobes high, rsp_err=1, rsp_rdata=0; no RDWAIT.
REQ-027 waitrequest falling in the same cycle the counter reaches TIMEOUT shall complete normally (completion wins).
REQ-028 avm_readdata and waitrequest shall be ignored outside ACCESS/RDWAIT.
REQ-029 cmd_valid outside IDLE shall be ignored (no queuing); back-to-back commands are separated by at least one IDLE cycle.

Reset
REQ-030 On rst: state IDLE, chipselect_n/write_n/read_n=1, avm_address/avm_writedata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counters 0, effective next cycle.
REQ-031 rst mid-transaction shall abort with no rsp_valid pulse.

Structure
REQ-032 Package avalon_udp_pkg shall hold the state encoding, bus width constant (16) and READ_LATENCY/TIMEOUT defaults.
REQ-033 One sub-module, avm_wait_timer (clear, enable, saturating count, terminal flag), shall be used for both the wait counter and the RDWAIT latency count.

Verification
REQ-034 Write addr 0x0012 data 0xBEEF, waitrequest=0 -> write_n low for exactly 1 cycle at T+1, rsp_valid at T+2, rsp_err=0.
REQ-035 Read addr 0x0034, waitrequest=0, READ_LATENCY=2, readdata=0x5A5A in A+2 -> rsp_valid at A+3, rsp_rdata=0x5A5A.
REQ-036 Write with waitrequest high 3 cycles -> strobe held 4 cycles, address/data stable, single rsp_valid, rsp_err=0.
REQ-037 TIMEOUT=4, waitrequest stuck high -> strobe low 4 cycles, rsp_valid next cycle with rsp_err=1, rsp_rdata=0, then IDLE.
REQ-038 rst asserted in RDWAIT -> strobes high, rsp_valid never pulses, cmd_ready=1 in first cycle after rst deasserts.
REQ-039 cmd_valid held high continuously for 3 reads -> exactly 3 accepted, one rsp_valid each, no overlapping strobes.
